route12_demux: RTL
==================

ROUTE12_DEMUX -- requirements
Module: route12_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per destination buffer (2 only; other values unsupported).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  source word present.
REQ-006 SHALL have port in_ready  output  1  word accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_sel  input  1  destination select: 0 selects out0, 1 selects out1.
REQ-008 SHALL have port in_data  input  WIDTH  source word.
REQ-009 SHALL have ports out0_valid/out1_valid  output  1  buffered word available at destination.
REQ-010 SHALL have ports out0_ready/out1_ready  input  1  destination consumes head word.
REQ-011 SHALL have ports out0_data/out1_data  output  WIDTH  head word of each destination buffer.
REQ-012 SHALL have ports out0_count/out1_count  output  2  current occupancy, 0..2.

Function
REQ-013 SHALL implement the inverse of a 2:1 select: each accepted word goes to exactly one destination buffer, chosen by in_sel sampled in the accept cycle.
REQ-014 SHALL accept a word (push) on a rising edge where in_valid and in_ready are both high.
REQ-015 SHALL drive in_ready = (occupancy of the buffer selected by in_sel) != 2; in_ready SHALL NOT depend on out0_ready/out1_ready.
REQ-016 SHALL pop a destination head on a rising edge where its outN_valid and outN_ready are both high.
REQ-017 SHALL give each destination buffer the states EMPTY (0), ONE (1), and FULL (2), with transitions: push only +1, pop only -1, push and pop together unchanged.
REQ-018 SHALL permit push and pop in the same cycle in state ONE; push in FULL is impossible by REQ-015; pop in EMPTY is impossible because outN_valid is low.
REQ-019 SHALL have latency 1: a word pushed at edge t is visible on outN_data with outN_valid high after edge t, when that buffer was EMPTY.
REQ-020 SHALL preserve FIFO order per destination; relative order across destinations is unconstrained.
REQ-021 SHALL hold outN_data stable while outN_valid is high and outN_ready is low.
REQ-022 SHALL keep outN_valid = (outN_count != 0).
REQ-023 SHALL hold outN_data at its last value when EMPTY (value not checked).
REQ-024 SHALL leave destination 0 unaffected when in_sel=1 with out1 FULL, including pops on out0 proceeding normally.
REQ-025 SHALL implement storage as two registered slots per destination with read/write pointers wrapping mod 2.

Reset
REQ-026 SHALL, on reset high at a rising edge, set out0_count, out1_count, out0_valid, and out1_valid to 0 and both pointers to 0; in_ready then follows REQ-015 and is high.
REQ-027 SHALL discard buffered words when reset is asserted mid-operation, ignoring any push or pop in that cycle.
REQ-028 SHALL NOT reset data slots; outN_data is don't-care while outN_valid is low.

Structure
REQ-029 SHALL place DEPTH-related constants (occupancy encodings EMPTY=0, ONE=1, FULL=2) in a shared package, mips_route_pkg.
REQ-030 SHALL instantiate one sub-module, fifo2, twice (one per destination); fifo2 holds slots, pointers, and count; route12_demux holds only select/ready logic.

Verification
REQ-031 SHALL verify basic route: push 0x0A5 with sel=0, then 0x5A0 with sel=1, both outputs ready -> out0_data=0x0A5 one cycle after its push, out1_data=0x5A0 one cycle after its push, counts return to 0.
REQ-032 SHALL verify backpressure/full: out0_ready=0, push 0x001, 0x002, 0x003 with sel=0 -> count 2, in_ready=0 on third, then out0_ready=1 -> pops 0x001, 0x002, then 0x003 accepted.
REQ-033 SHALL verify isolation: out1 FULL, in_sel=1 then switch to in_sel=0 -> in_ready goes 0 then 1; 0xFFF appears on out0 while out1 contents unchanged.
REQ-034 SHALL verify simultaneous push and pop in ONE: out0 holds 0x111, push 0x222 sel=0 and pop together -> count stays 1, out0_data=0x222.
REQ-035 SHALL verify reset mid-stream: both buffers FULL, assert reset one cycle with in_valid=1 -> counts 0, outN_valid=0, in_ready=1, no word from the reset cycle appears.
REQ-036 SHALL verify random stress: 10,000 cycles of random valid/ready/sel -> per-destination scoreboard order match, no loss or duplication, count never exceeds 2.

Source files
------------

// File: rtl/mips_route_pkg.sv
// ============================================================================
// mips_route_pkg : occupancy encodings shared by the route12 demux slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_route_pkg;

  localparam int c_depth = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/route12_demux_fifo2.sv
// ============================================================================
// fifo2 : two-slot per-destination buffer with wrapping pointers and count
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo2
  import mips_route_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_slot [2];
  logic             r_wptr;
  logic             r_rptr;
  occ_e             r_state;
  occ_e             w_state_nxt;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard locally so a stray push into FULL or pop from EMPTY cannot corrupt state.
  assign w_do_push = push && (r_state != FULL);
  assign w_do_pop  = pop && (r_state != EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_do_push) w_state_nxt = ONE;
      ONE: begin
        if (w_do_push && !w_do_pop)      w_state_nxt = FULL;
        else if (!w_do_push && w_do_pop) w_state_nxt = EMPTY;
      end
      FULL:    if (w_do_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
    end
  end

  // Data slots carry no reset; contents are meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (w_do_push && !reset) r_slot[r_wptr] <= push_data;
  end

  assign valid = (r_state != EMPTY);
  assign data  = r_slot[r_rptr];
  assign count = r_state;

endmodule

`default_nettype wire

// File: rtl/route12_demux.sv
// ============================================================================
// route12_demux : 1-to-2 stream demux steering each word into a 2-deep buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module route12_demux
  import mips_route_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [1:0]       out0_count,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [1:0]       out1_count
);

  generate
    if (DEPTH != c_depth) begin : g_bad_depth
      $error("route12_demux supports DEPTH=2 only");
    end
  endgenerate

  logic w_push0;
  logic w_push1;

  // Ready looks only at the selected buffer's occupancy, never at downstream ready.
  assign in_ready = in_sel ? (out1_count != FULL) : (out0_count != FULL);
  assign w_push0  = in_valid && in_ready && !in_sel;
  assign w_push1  = in_valid && in_ready && in_sel;

  fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .count     (out0_count)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .count     (out1_count)
  );

endmodule

`default_nettype wire
